// File: rtl/msi_pkg.sv
//------------------------------------------------------------------------------
// msi_pkg
// Shared MSI state, bus opcode and snoop-FSM encodings plus the snoop update rule.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package msi_pkg;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    localparam logic [1:0] OP_READ_MISS  = 2'b00;
    localparam logic [1:0] OP_WRITE_MISS = 2'b01;
    localparam logic [1:0] OP_INVALIDATE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_DONE      = 2'd3
    } snoop_fsm_e;

    // The unused encoding 11 is never stored; it collapses to Invalid.
    function automatic logic [1:0] msi_sanitize(input logic [1:0] s);
        return (s == 2'b11) ? MSI_I : s;
    endfunction

    function automatic logic [1:0] msi_snoop_next(input logic [1:0] op, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        case (op)
            OP_READ_MISS:                 if (cur == MSI_M) r = MSI_S;
            OP_WRITE_MISS, OP_INVALIDATE: r = MSI_I;
            default:                      r = cur;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msi_snoop_responder_if.sv
//------------------------------------------------------------------------------
// msi_snoop_responder_if
// Snooped bus, memory writeback, fill and line-display signals of the responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface msi_snoop_responder_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic              bus_valid;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_address;
    logic              bus_ready;
    logic              bus_done;
    logic              bus_shared;
    logic              bus_abort;

    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ready;

    logic              fill_valid;
    logic [ADDR_W-1:0] fill_address;
    logic [DATA_W-1:0] fill_data;
    logic [1:0]        fill_state;
    logic              fill_ready;

    logic [1:0]        current_state;
    logic [ADDR_W-1:0] current_address;
    logic [DATA_W-1:0] current_data;

    modport slave (
        input  bus_valid, bus_op, bus_address, mem_wr_ready,
               fill_valid, fill_address, fill_data, fill_state,
        output bus_ready, bus_done, bus_shared, bus_abort,
               mem_wr_valid, mem_wr_address, mem_wr_data, fill_ready,
               current_state, current_address, current_data
    );

    modport master (
        output bus_valid, bus_op, bus_address, mem_wr_ready,
               fill_valid, fill_address, fill_data, fill_state,
        input  bus_ready, bus_done, bus_shared, bus_abort,
               mem_wr_valid, mem_wr_address, mem_wr_data, fill_ready,
               current_state, current_address, current_data
    );
endinterface

`default_nettype wire

// File: rtl/msi_line_array.sv
//------------------------------------------------------------------------------
// msi_line_array
// Direct-mapped state/tag/data store: one write port (snoop state update wins
// over fill) and a combinational read port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module msi_line_array #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 1,
    parameter int DATA_W  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               fill_en_i,
    input  wire logic [INDEX_W-1:0] fill_idx_i,
    input  wire logic [1:0]         fill_state_i,
    input  wire logic [TAG_W-1:0]   fill_tag_i,
    input  wire logic [DATA_W-1:0]  fill_data_i,
    input  wire logic               snp_en_i,
    input  wire logic [INDEX_W-1:0] snp_idx_i,
    input  wire logic [1:0]         snp_state_i,
    input  wire logic [INDEX_W-1:0] rd_idx_i,
    output logic [1:0]              rd_state_o,
    output logic [TAG_W-1:0]        rd_tag_o,
    output logic [DATA_W-1:0]       rd_data_o
);
    localparam int LINES = 1 << INDEX_W;

    logic [1:0]        state_q [LINES];
    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [DATA_W-1:0] data_q  [LINES];

    // A snoop only ever rewrites the state field; tag and data stay untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= '0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (snp_en_i) begin
            state_q[snp_idx_i] <= snp_state_i;
        end else if (fill_en_i) begin
            state_q[fill_idx_i] <= fill_state_i;
            tag_q[fill_idx_i]   <= fill_tag_i;
            data_q[fill_idx_i]  <= fill_data_i;
        end
    end

    assign rd_state_o = state_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/msi_snoop_responder.sv
//------------------------------------------------------------------------------
// msi_snoop_responder
// Bus-side MSI snoop engine: lookup, downgrade/invalidate, Modified writeback.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module msi_snoop_responder
    import msi_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int INDEX_W = 2
) (
    input  wire logic            clock,
    input  wire logic            resetn,
    msi_snoop_responder_if.slave bus_if
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    snoop_fsm_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              shared_q, shared_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic               w_snp_en;
    logic               w_fill_en;
    logic               w_hit;
    logic [INDEX_W-1:0] w_idx;
    logic [1:0]         w_rd_state;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_idx     = addr_q[INDEX_W-1:0];
    assign w_fill_en = bus_if.fill_valid && bus_if.fill_ready;
    assign w_hit     = (w_rd_tag == addr_q[ADDR_W-1:INDEX_W]) && (w_rd_state != MSI_I)
                       && (op_q != 2'b11);

    msi_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk          (clock),
        .rst_n        (resetn),
        .fill_en_i    (w_fill_en),
        .fill_idx_i   (bus_if.fill_address[INDEX_W-1:0]),
        .fill_state_i (msi_sanitize(bus_if.fill_state)),
        .fill_tag_i   (bus_if.fill_address[ADDR_W-1:INDEX_W]),
        .fill_data_i  (bus_if.fill_data),
        .snp_en_i     (w_snp_en),
        .snp_idx_i    (w_idx),
        .snp_state_i  (msi_snoop_next(op_q, w_rd_state)),
        .rd_idx_i     (w_idx),
        .rd_state_o   (w_rd_state),
        .rd_tag_o     (w_rd_tag),
        .rd_data_o    (w_rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            shared_q  <= 1'b0;
            abort_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            shared_q  <= shared_d;
            abort_q   <= abort_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        shared_d  = shared_q;
        abort_d   = abort_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        w_snp_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.bus_valid) begin
                    op_d    = bus_if.bus_op;
                    addr_d  = bus_if.bus_address;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                shared_d = w_hit;
                // A Modified hit must reach memory before the state may change.
                if (w_hit && (w_rd_state == MSI_M)) begin
                    wr_addr_d = {w_rd_tag, w_idx};
                    wr_data_d = w_rd_data;
                    state_d   = ST_WRITEBACK;
                end else begin
                    w_snp_en = w_hit;
                    abort_d  = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_WRITEBACK: begin
                if (bus_if.mem_wr_ready) begin
                    w_snp_en = 1'b1;
                    abort_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                shared_d = 1'b0;
                abort_d  = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_if.bus_ready       = (state_q == ST_IDLE);
    assign bus_if.bus_done        = (state_q == ST_DONE);
    assign bus_if.bus_shared      = shared_q;
    assign bus_if.bus_abort       = abort_q;
    assign bus_if.mem_wr_valid    = (state_q == ST_WRITEBACK);
    assign bus_if.mem_wr_address  = wr_addr_q;
    assign bus_if.mem_wr_data     = wr_data_q;
    assign bus_if.fill_ready      = (state_q == ST_IDLE) && !bus_if.bus_valid;
    assign bus_if.current_state   = w_rd_state;
    assign bus_if.current_address = {w_rd_tag, w_idx};
    assign bus_if.current_data    = w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_msi_snoop_responder.sv
//------------------------------------------------------------------------------
// tb_msi_snoop_responder
// Directed snoop scenarios with queued expectations checked by a bus monitor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_msi_snoop_responder;
    import msi_pkg::*;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 4;
    localparam int INDEX_W = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    msi_snoop_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    msi_snoop_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus_if (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] done_sb [$];
    logic [6:0] wb_sb   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : monitor
        logic [1:0] ed;
        logic [6:0] ew;
        if (bif.bus_done) begin
            if (done_sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                ed = done_sb.pop_front();
                check("done_shared", {31'd0, bif.bus_shared}, {31'd0, ed[1]});
                check("done_abort",  {31'd0, bif.bus_abort},  {31'd0, ed[0]});
            end
        end
        if (bif.mem_wr_valid && bif.mem_wr_ready) begin
            if (wb_sb.size() == 0) begin
                check("unexpected_writeback", 1, 0);
            end else begin
                ew = wb_sb.pop_front();
                check("wb_address", {29'd0, bif.mem_wr_address}, {29'd0, ew[6:4]});
                check("wb_data",    {28'd0, bif.mem_wr_data},    {28'd0, ew[3:0]});
            end
        end
    end

    task automatic exp_done(input logic sh, input logic ab);
        done_sb.push_back({sh, ab});
    endtask

    task automatic exp_wb(input logic [2:0] a, input logic [3:0] d);
        wb_sb.push_back({a, d});
    endtask

    task automatic fill(input logic [2:0] a, input logic [3:0] d, input logic [1:0] s);
        bif.fill_valid   = 1'b1;
        bif.fill_address = a;
        bif.fill_data    = d;
        bif.fill_state   = s;
        @(negedge clock);
        check("fill_ready", {31'd0, bif.fill_ready}, 1);
        @(posedge clock); #1;
        bif.fill_valid = 1'b0;
    endtask

    // Called one time unit after a rising edge with the block idle.
    task automatic snoop(input logic [1:0] op, input logic [2:0] a, output int lat);
        lat = 0;
        bif.bus_valid   = 1'b1;
        bif.bus_op      = op;
        bif.bus_address = a;
        @(posedge clock); #1;
        bif.bus_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (bif.bus_done) break;
        end
        if (!bif.bus_done) check("done_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic check_line(input string name, input logic [1:0] s, input logic [2:0] a,
                              input logic [3:0] d);
        check({name, "_state"},   {30'd0, bif.current_state},   {30'd0, s});
        check({name, "_address"}, {29'd0, bif.current_address}, {29'd0, a});
        check({name, "_data"},    {28'd0, bif.current_data},    {28'd0, d});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        bif.bus_valid    = 1'b0;
        bif.bus_op       = 2'b00;
        bif.bus_address  = '0;
        bif.mem_wr_ready = 1'b1;
        bif.fill_valid   = 1'b0;
        bif.fill_address = '0;
        bif.fill_data    = '0;
        bif.fill_state   = 2'b00;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_bus_ready",   {31'd0, bif.bus_ready}, 1);
        check("rst_bus_done",    {31'd0, bif.bus_done}, 0);
        check("rst_bus_shared",  {31'd0, bif.bus_shared}, 0);
        check("rst_bus_abort",   {31'd0, bif.bus_abort}, 0);
        check("rst_mem_wr_valid", {31'd0, bif.mem_wr_valid}, 0);
        check("rst_mem_wr_address", {29'd0, bif.mem_wr_address}, 0);
        check("rst_mem_wr_data", {28'd0, bif.mem_wr_data}, 0);
        check_line("rst_line", MSI_I, 3'b000, 4'h0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Modified hit on READ_MISS: writeback, then shared + abort, line -> S
        fill(3'b101, 4'hA, MSI_M);
        exp_wb(3'b101, 4'hA);
        exp_done(1'b1, 1'b1);
        snoop(OP_READ_MISS, 3'b101, lat);
        check("m_read_latency", lat, 3);
        check_line("m_read_line", MSI_S, 3'b101, 4'hA);

        // Shared hit on WRITE_MISS: no writeback, line -> I
        fill(3'b010, 4'h5, MSI_S);
        exp_done(1'b1, 1'b0);
        snoop(OP_WRITE_MISS, 3'b010, lat);
        check("s_write_latency", lat, 2);
        check_line("s_write_line", MSI_I, 3'b010, 4'h5);

        // Tag mismatch against an M line: pure miss
        fill(3'b001, 4'h3, MSI_M);
        exp_done(1'b0, 1'b0);
        snoop(OP_READ_MISS, 3'b101, lat);
        check("miss_latency", lat, 2);
        check_line("miss_line", MSI_M, 3'b001, 4'h3);

        // Writeback stalled by memory for five cycles
        exp_wb(3'b001, 4'h3);
        exp_done(1'b1, 1'b1);
        bif.mem_wr_ready = 1'b0;
        bif.bus_valid    = 1'b1;
        bif.bus_op       = OP_WRITE_MISS;
        bif.bus_address  = 3'b001;
        @(posedge clock); #1;
        bif.bus_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_wr_valid",   {31'd0, bif.mem_wr_valid}, 1);
            check("stall_wr_address", {29'd0, bif.mem_wr_address}, 32'd1);
            check("stall_wr_data",    {28'd0, bif.mem_wr_data}, 32'd3);
            check("stall_bus_ready",  {31'd0, bif.bus_ready}, 0);
            check("stall_fill_ready", {31'd0, bif.fill_ready}, 0);
            check("stall_no_done",    {31'd0, bif.bus_done}, 0);
        end
        @(posedge clock); #1;
        bif.mem_wr_ready = 1'b1;
        @(negedge clock);
        check("stall_done_early", {31'd0, bif.bus_done}, 0);
        @(negedge clock);
        check("stall_done_after_ready", {31'd0, bif.bus_done}, 1);
        @(posedge clock); #1;
        check_line("stall_line", MSI_I, 3'b001, 4'h3);

        // INVALIDATE on M behaves like WRITE_MISS
        fill(3'b110, 4'hC, MSI_M);
        exp_wb(3'b110, 4'hC);
        exp_done(1'b1, 1'b1);
        snoop(OP_INVALIDATE, 3'b110, lat);
        check("m_inv_latency", lat, 3);
        check_line("m_inv_line", MSI_I, 3'b110, 4'hC);

        // INVALIDATE on S
        fill(3'b011, 4'h7, MSI_S);
        exp_done(1'b1, 1'b0);
        snoop(OP_INVALIDATE, 3'b011, lat);
        check("s_inv_latency", lat, 2);
        check_line("s_inv_line", MSI_I, 3'b011, 4'h7);

        // Reserved opcode against an M line: no effect
        fill(3'b111, 4'h9, MSI_M);
        exp_done(1'b0, 1'b0);
        snoop(2'b11, 3'b111, lat);
        check("rsvd_latency", lat, 2);
        check_line("rsvd_line", MSI_M, 3'b111, 4'h9);

        // Fill with illegal state 11 is stored as I
        fill(3'b000, 4'h1, 2'b11);
        exp_done(1'b0, 1'b0);
        snoop(OP_READ_MISS, 3'b000, lat);
        check_line("illegal_fill_line", MSI_I, 3'b000, 4'h1);

        // Fill and snoop in the same cycle: snoop wins, fill lands after DONE
        exp_done(1'b0, 1'b0);
        bif.fill_valid   = 1'b1;
        bif.fill_address = 3'b100;
        bif.fill_data    = 4'hF;
        bif.fill_state   = MSI_M;
        bif.bus_valid    = 1'b1;
        bif.bus_op       = OP_READ_MISS;
        bif.bus_address  = 3'b100;
        @(negedge clock);
        check("collide_fill_ready", {31'd0, bif.fill_ready}, 0);
        @(posedge clock); #1;
        bif.bus_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("collide_busy_fill_ready", {31'd0, bif.fill_ready}, 0);
        end
        check("collide_done", {31'd0, bif.bus_done}, 1);
        check_line("collide_pre_fill", MSI_I, 3'b000, 4'h1);
        @(negedge clock);
        check("collide_idle_fill_ready", {31'd0, bif.fill_ready}, 1);
        @(posedge clock); #1;
        bif.fill_valid = 1'b0;
        check_line("collide_post_fill", MSI_M, 3'b100, 4'hF);

        // Reset asserted in the middle of a writeback
        bif.mem_wr_ready = 1'b0;
        bif.bus_valid    = 1'b1;
        bif.bus_op       = OP_READ_MISS;
        bif.bus_address  = 3'b100;
        @(posedge clock); #1;
        bif.bus_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rstwb_wr_valid_before", {31'd0, bif.mem_wr_valid}, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("rstwb_wr_valid_dropped", {31'd0, bif.mem_wr_valid}, 0);
        check("rstwb_no_done", {31'd0, bif.bus_done}, 0);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        bif.mem_wr_ready = 1'b1;
        @(posedge clock); #1;
        check("rstwb_bus_ready", {31'd0, bif.bus_ready}, 1);
        check_line("rstwb_line0", MSI_I, 3'b000, 4'h0);
        exp_done(1'b0, 1'b0);
        snoop(OP_READ_MISS, 3'b011, lat);
        check_line("rstwb_line3", MSI_I, 3'b011, 4'h0);
        exp_done(1'b0, 1'b0);
        snoop(OP_READ_MISS, 3'b111, lat);

        @(posedge clock); #1;
        check("sb_done_empty", done_sb.size(), 0);
        check("sb_wb_empty", wb_sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
